// File: rtl/pb_intf_pkg.sv
// rtl/pb_intf_pkg.sv - shared push-button event/state types and level-to-scale mapping
package pb_intf_pkg;

    typedef enum logic [1:0] {EVT_NONE, EVT_SHORT, EVT_LONG} pb_evt_t;
    typedef enum logic [1:0] {ARM, IDLE, HELD, LONG} pb_state_t;

    // Rounded linear map of level onto 0..2^scale_w-1; ends land exactly on 0 and full scale
    function automatic int unsigned lvl2scale(input int unsigned lvl,
                                              input int unsigned num_lvl,
                                              input int unsigned scale_w);
        int unsigned full;
        full = (32'd1 << scale_w) - 32'd1;
        return (lvl * full + (num_lvl - 32'd1) / 32'd2) / (num_lvl - 32'd1);
    endfunction

endpackage

// File: rtl/pb_debounce.sv
// rtl/pb_debounce.sv - per-button synchroniser, debouncer and press FSM; long press under PB_LONG_PRESS_EN
module pb_debounce
    import pb_intf_pkg::*;
#(
    parameter int DBNC_CYC = 16,
    parameter int LONG_CYC = 1024
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    btn_n,
    output pb_evt_t evt
);

    localparam int DW = $clog2(DBNC_CYC + 1);

    logic          s1_q, s1_d, s2_q, s2_d;
    logic          deb_q, deb_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [1:0]    flush_q, flush_d;
    pb_state_t     state_q, state_d;
`ifdef PB_LONG_PRESS_EN
    localparam int HW = $clog2(LONG_CYC + 1);
    logic [HW-1:0] hold_q, hold_d;
`endif

    always_comb begin
        s1_d    = btn_n;
        s2_d    = s1_q;
        deb_d   = deb_q;
        dcnt_d  = '0;
        flush_d = (flush_q == 2'd2) ? flush_q : flush_q + 2'd1;
        if (s2_q != deb_q) begin
            if (dcnt_q == DW'(DBNC_CYC - 1)) deb_d = s2_q;
            else                             dcnt_d = dcnt_q + 1'b1;
        end

        state_d = state_q;
        evt     = EVT_NONE;
`ifdef PB_LONG_PRESS_EN
        hold_d  = hold_q;
`endif
        case (state_q)
            // Leave only once the synchroniser carries real input and shows a release
            ARM:  if (flush_q == 2'd2 && deb_q && s2_q) state_d = IDLE;
            IDLE: if (!deb_q) begin
                state_d = HELD;
`ifdef PB_LONG_PRESS_EN
                hold_d  = '0;
`endif
            end
            HELD: begin
`ifdef PB_LONG_PRESS_EN
                hold_d = (hold_q == HW'(LONG_CYC)) ? hold_q : hold_q + 1'b1;
`endif
                if (deb_q) begin
                    evt     = EVT_SHORT;
                    state_d = IDLE;
                end
`ifdef PB_LONG_PRESS_EN
                // IDLE cycle plus this one complete LONG_CYC held cycles since the debounced press
                else if (hold_q == HW'(LONG_CYC - 2)) begin
                    evt     = EVT_LONG;
                    state_d = LONG;
                end
`endif
            end
            default: if (deb_q) state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            deb_q   <= 1'b1;
            dcnt_q  <= '0;
            flush_q <= '0;
            state_q <= ARM;
`ifdef PB_LONG_PRESS_EN
            hold_q  <= '0;
`endif
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            deb_q   <= deb_d;
            dcnt_q  <= dcnt_d;
            flush_q <= flush_d;
            state_q <= state_d;
`ifdef PB_LONG_PRESS_EN
            hold_q  <= hold_d;
`endif
        end
    end

endmodule

// File: rtl/pb_assist_ctrl.sv
// rtl/pb_assist_ctrl.sv - two-button assist level stepper with scale map; long press under PB_LONG_PRESS_EN
module pb_assist_ctrl
    import pb_intf_pkg::*;
#(
    parameter int NUM_LVL  = 4,
    parameter int SCALE_W  = 3,
    parameter int DBNC_CYC = 16,
    parameter int LONG_CYC = 1024,
    parameter int RST_LVL  = 2,
    parameter int WRAP     = 1,
    localparam int LVL_W   = $clog2(NUM_LVL)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tgglUp,
    input  logic               tgglDn,
    output logic [LVL_W-1:0]   setting,
    output logic [SCALE_W-1:0] scale,
    output logic               lvl_chg,
    output logic               long_press
);

    localparam logic [LVL_W-1:0] MAX_LVL = LVL_W'(NUM_LVL - 1);
    localparam logic [LVL_W-1:0] RST_VAL = LVL_W'(RST_LVL);

    pb_evt_t          up_evt, dn_evt;
    logic             up_long, dn_long, up_short, dn_short;
    logic [LVL_W-1:0] setting_q, setting_d;
    logic             lvl_chg_q, lvl_chg_d;
    logic             long_press_q, long_press_d;

    pb_debounce #(.DBNC_CYC(DBNC_CYC), .LONG_CYC(LONG_CYC)) u_up (
        .clk(clk), .rst_n(rst_n), .btn_n(tgglUp), .evt(up_evt)
    );
    pb_debounce #(.DBNC_CYC(DBNC_CYC), .LONG_CYC(LONG_CYC)) u_dn (
        .clk(clk), .rst_n(rst_n), .btn_n(tgglDn), .evt(dn_evt)
    );

    always_comb begin
        up_long   = (up_evt == EVT_LONG);
        dn_long   = (dn_evt == EVT_LONG);
        up_short  = (up_evt == EVT_SHORT);
        dn_short  = (dn_evt == EVT_SHORT);
        setting_d = setting_q;
        // Long beats short; down long wins a long-long tie; opposing shorts cancel
        if (up_long || dn_long)
            setting_d = dn_long ? '0 : MAX_LVL;
        else if (up_short && !dn_short)
            setting_d = (setting_q == MAX_LVL) ? ((WRAP != 0) ? '0 : MAX_LVL) : setting_q + 1'b1;
        else if (dn_short && !up_short)
            setting_d = (setting_q == '0) ? ((WRAP != 0) ? MAX_LVL : '0) : setting_q - 1'b1;
        lvl_chg_d = (setting_d != setting_q);
`ifdef PB_LONG_PRESS_EN
        long_press_d = up_long || dn_long;
`else
        long_press_d = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            setting_q    <= RST_VAL;
            lvl_chg_q    <= 1'b0;
            long_press_q <= 1'b0;
        end else begin
            setting_q    <= setting_d;
            lvl_chg_q    <= lvl_chg_d;
            long_press_q <= long_press_d;
        end
    end

    assign setting    = setting_q;
    assign scale      = SCALE_W'(lvl2scale(32'(setting_q), NUM_LVL, SCALE_W));
    assign lvl_chg    = lvl_chg_q;
    assign long_press = long_press_q;

endmodule

// File: tb/tb_pb_assist_ctrl.sv
// tb/tb_pb_assist_ctrl.sv - directed self-checking bench for pb_assist_ctrl (PB_LONG_PRESS_EN aware)
module tb_pb_assist_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       up_n = 1'b1, dn_n = 1'b1, sup_n = 1'b1, sdn_n = 1'b1;
    logic [1:0] setting, s_setting;
    logic [2:0] scale, s_scale;
    logic       lvl_chg, long_press, s_chg, s_long;
    int         n_chk = 0, n_fail = 0;
    int         chg_n = 0, long_n = 0, s_chg_n = 0;
    int         base, lbase;

    always #5 clk = ~clk;

    pb_assist_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .tgglUp(up_n), .tgglDn(dn_n),
        .setting(setting), .scale(scale), .lvl_chg(lvl_chg), .long_press(long_press)
    );

    pb_assist_ctrl #(.WRAP(0), .RST_LVL(0)) u_sat (
        .clk(clk), .rst_n(rst_n), .tgglUp(sup_n), .tgglDn(sdn_n),
        .setting(s_setting), .scale(s_scale), .lvl_chg(s_chg), .long_press(s_long)
    );

    always @(negedge clk) begin
        if (lvl_chg)    chg_n   <= chg_n + 1;
        if (long_press) long_n  <= long_n + 1;
        if (s_chg)      s_chg_n <= s_chg_n + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input int id, input logic v);
        case (id)
            0:       up_n  = v;
            1:       dn_n  = v;
            2:       sup_n = v;
            default: sdn_n = v;
        endcase
    endtask

    task automatic short_press(input int id);
        set_btn(id, 1'b0);
        edges(30);
        set_btn(id, 1'b1);
        edges(25);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        edges(3);
        check("rst_setting", setting, 2);
        check("rst_scale", scale, 5);
        check("rst_lvl_chg", lvl_chg, 0);
        check("rst_long", long_press, 0);
        rst_n = 1'b1;
        edges(3);

        base = chg_n;
        short_press(0);
        check("up1_setting", setting, 3);
        check("up1_scale", scale, 7);
        short_press(0);
        check("wrap_setting", setting, 0);
        check("wrap_scale", scale, 0);
        short_press(0);
        check("up3_setting", setting, 1);
        check("up3_scale", scale, 2);
        check("up_chg_count", chg_n - base, 3);

        base = chg_n;
        repeat (2) begin
            set_btn(0, 1'b0);
            edges(15);
            set_btn(0, 1'b1);
            edges(30);
        end
        check("glitch_setting", setting, 1);
        check("glitch_chg", chg_n - base, 0);

        base = chg_n;
        set_btn(0, 1'b0);
        edges(30);
        set_btn(0, 1'b1);
        edges(5);
        set_btn(0, 1'b0);
        edges(1);
        set_btn(0, 1'b1);
        edges(18);
        check("rel_glitch_early", setting, 1);
        edges(1);
        check("rel_glitch_update", setting, 2);
        check("rel_glitch_pulse", lvl_chg, 1);
        edges(1);
        check("rel_glitch_pulse_end", lvl_chg, 0);
        edges(30);
        check("rel_glitch_final", setting, 2);
        check("rel_glitch_chg", chg_n - base, 1);

        base = chg_n;
        up_n = 1'b0; dn_n = 1'b0;
        edges(30);
        up_n = 1'b1; dn_n = 1'b1;
        edges(30);
        check("both_short_setting", setting, 2);
        check("both_short_chg", chg_n - base, 0);

        short_press(0);
        check("pre_long_setting", setting, 3);
        base  = chg_n;
        lbase = long_n;
`ifdef PB_LONG_PRESS_EN
        dn_n = 1'b0;
        edges(1041);
        check("long_early", setting, 3);
        edges(1);
        check("long_setting", setting, 0);
        check("long_pulse", long_press, 1);
        check("long_chg_pulse", lvl_chg, 1);
        edges(58);
        dn_n = 1'b1;
        edges(40);
        check("long_release_setting", setting, 0);
        check("long_count", long_n - lbase, 1);
        check("long_chg_count", chg_n - base, 1);

        short_press(0);
        check("mix_pre", setting, 1);
        up_n = 1'b0;
        edges(100);
        dn_n = 1'b0;
        edges(923);
        dn_n = 1'b1;
        edges(18);
        check("mix_early", setting, 1);
        edges(1);
        check("mix_setting", setting, 3);
        check("mix_long_pulse", long_press, 1);
        edges(20);
        up_n = 1'b1;
        edges(40);
        check("mix_final", setting, 3);
`else
        dn_n = 1'b0;
        edges(1100);
        check("held_no_long", setting, 3);
        dn_n = 1'b1;
        edges(19);
        check("held_release_setting", setting, 2);
        edges(5);
        check("held_long_count", long_n - lbase, 0);
        check("held_chg_count", chg_n - base, 1);
`endif

        up_n = 1'b0;
        edges(30);
        rst_n = 1'b0;
        edges(2);
        check("midpress_rst_setting", setting, 2);
        rst_n = 1'b1;
        base = chg_n;
        edges(40);
        up_n = 1'b1;
        edges(40);
        check("arm_setting", setting, 2);
        check("arm_chg", chg_n - base, 0);
        short_press(0);
        check("arm_second_setting", setting, 3);
        check("arm_second_chg", chg_n - base, 1);

        base = s_chg_n;
        short_press(3);
        check("sat_dn_setting", s_setting, 0);
        check("sat_dn_chg", s_chg_n - base, 0);
        repeat (3) short_press(2);
        check("sat_up3_setting", s_setting, 3);
        short_press(2);
        check("sat_up4_setting", s_setting, 3);
        check("sat_up4_scale", s_scale, 7);
        check("sat_up_chg", s_chg_n - base, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
